// File: rtl/dbus_sram_responder_pkg.sv
// rtl/dbus_sram_responder_pkg.sv - dbus request/response types, responder FSM states and limits
package dbus_sram_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    localparam int RESP_MAX_LATENCY = 15;

endpackage

// File: rtl/dbus_sram_responder_if.sv
// rtl/dbus_sram_responder_if.sv - dbus request/response bundle with core and memory views
interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder_bytewrite_ram.sv
// rtl/dbus_sram_responder_bytewrite_ram.sv - word RAM with per-byte write enables, async read
module bytewrite_ram #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    // Contents start at zero and are never touched by reset.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - dbus slave: one transaction at a time on an internal SRAM
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_sram_responder_if.slave  dbus,
    input  logic                  stall
);

    localparam int         AW         = $clog2(DEPTH);
    localparam int         CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0] CNT_INIT   = 4'(CNT_INIT_I);

    resp_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    strobe_q, strobe_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          data_ok_q, data_ok_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          addr_ok;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] raddr;
    logic [31:0]   mem_rdata;
    logic [3:0]    we;
    logic          unused_req;

    // Byte offset, size and upper address bits play no part in addressing.
    assign req_idx    = dbus.dreq.addr[AW+1:2];
    assign unused_req = ^{dbus.dreq.size, dbus.dreq.addr[31:AW+2], dbus.dreq.addr[1:0]};

    assign addr_ok = ~reset & (state_q == IDLE) & dbus.dreq.valid & ~stall;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        raddr    = idx_q;

        case (state_q)
            IDLE: begin
                if (addr_ok) begin
                    idx_d    = req_idx;
                    strobe_d = dbus.dreq.strobe;
                    wdata_d  = dbus.dreq.data;
                    // With zero latency the RAM is read straight from the live request.
                    raddr    = req_idx;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        rdata_d = (dbus.dreq.strobe == 4'b0) ? mem_rdata : 32'h0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!stall) begin
                    if (cnt_q == 4'd0) begin
                        state_d = RESP;
                        rdata_d = (strobe_q == 4'b0) ? mem_rdata : 32'h0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        data_ok_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            strobe_q  <= 4'b0;
            wdata_q   <= 32'h0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            strobe_q  <= strobe_d;
            wdata_q   <= wdata_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    // Write commits on the edge leaving RESP, before any following accept.
    assign we = (state_q == RESP) ? strobe_q : 4'b0;

    bytewrite_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (raddr),
        .rdata (mem_rdata)
    );

    assign dbus.dresp = '{addr_ok: addr_ok, data_ok: data_ok_q, data: rdata_q};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - directed bench for dbus_sram_responder (LATENCY=2 and LATENCY=0 instances)
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_a = 1'b0;
    logic stall_b = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    dbus_sram_responder_if bus_a ();
    dbus_sram_responder_if bus_b ();

    dbus_sram_responder #(.DEPTH(4096), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .dbus  (bus_a),
        .stall (stall_a)
    );

    dbus_sram_responder #(.DEPTH(1024), .LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .dbus  (bus_b),
        .stall (stall_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_req(input bit b, input logic v, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] data);
        dbus_req_t r;
        r = '{valid: v, addr: addr, size: 3'd2, strobe: strb, data: data};
        if (b) bus_b.dreq = r;
        else   bus_a.dreq = r;
    endtask

    function automatic dbus_resp_t get_resp(input bit b);
        return b ? bus_b.dresp : bus_a.dresp;
    endfunction

    task automatic set_stall(input bit b, input logic s);
        if (b) stall_b = s;
        else   stall_a = s;
    endtask

    // Issue one transaction starting just after a rising edge; returns accept and data_ok cycles.
    task automatic txn(input bit b, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data, input int stall_n, input string name,
                       output int t_acc, output int t_ok, output logic [31:0] rdata);
        dbus_resp_t r;
        set_req(b, 1'b1, addr, strb, data);
        #1;
        r = get_resp(b);
        n_total++;
        if (r.addr_ok !== 1'b1) $display("FAIL %s accept: addr_ok=%b expected 1", name, r.addr_ok);
        else n_pass++;
        t_acc = cyc;
        t_ok  = -1;
        rdata = 32'hx;
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            set_stall(b, i < stall_n);
            #1;
            r = get_resp(b);
            if (r.data_ok === 1'b1) begin
                t_ok  = cyc;
                rdata = r.data;
                break;
            end
            n_total++;
            if (r.addr_ok !== 1'b0) $display("FAIL %s busy: addr_ok=%b expected 0", name, r.addr_ok);
            else n_pass++;
            @(posedge clk); #1;
        end
        set_stall(b, 1'b0);
        set_req(b, 1'b0, 32'h0, 4'h0, 32'h0);
        n_total++;
        if (t_ok < 0) $display("FAIL %s timeout: data_ok never seen within 40 cycles", name);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        dbus_resp_t r;
        set_req(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        set_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        r = get_resp(1'b0);
        n_total++;
        if (r.addr_ok !== 1'b0) $display("FAIL reset addr_ok: got %b expected 0", r.addr_ok);
        else n_pass++;
        n_total++;
        if (r.data_ok !== 1'b0) $display("FAIL reset data_ok: got %b expected 0", r.data_ok);
        else n_pass++;
        n_total++;
        if (r.data !== 32'h0) $display("FAIL reset data: got %h expected 00000000", r.data);
        else n_pass++;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        r = get_resp(1'b0);
        n_total++;
        if (r.addr_ok !== 1'b1) $display("FAIL release addr_ok: got %b expected 1", r.addr_ok);
        else n_pass++;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int ta_w, to_w, ta_r, to_r;
        logic [31:0] d;
        txn(1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 0, "wr_full", ta_w, to_w, d);
        n_total++;
        if (to_w - ta_w !== 3) $display("FAIL wr_full latency: got %0d expected 3", to_w - ta_w);
        else n_pass++;
        txn(1'b0, 32'h100, 4'h0, 32'h0, 0, "rd_full", ta_r, to_r, d);
        n_total++;
        if (ta_r - ta_w !== 4) $display("FAIL back_to_back accept: got T+%0d expected T+4", ta_r - ta_w);
        else n_pass++;
        n_total++;
        if (to_r - ta_w !== 7) $display("FAIL rd_full data_ok: got T+%0d expected T+7", to_r - ta_w);
        else n_pass++;
        n_total++;
        if (d !== 32'hDEADBEEF) $display("FAIL rd_full data: got %h expected deadbeef", d);
        else n_pass++;
    endtask

    task automatic test_byte_strobe();
        int ta, to;
        logic [31:0] d;
        txn(1'b0, 32'h100, 4'b0010, 32'h0000AA00, 0, "wr_byte", ta, to, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL wr_byte resp data: got %h expected 00000000", d);
        else n_pass++;
        txn(1'b0, 32'h100, 4'h0, 32'h0, 0, "rd_byte", ta, to, d);
        n_total++;
        if (d !== 32'hDEADAAEF) $display("FAIL rd_byte data: got %h expected deadaaef", d);
        else n_pass++;
    endtask

    task automatic test_stall();
        int ta, to;
        logic [31:0] d;
        txn(1'b0, 32'h100, 4'h0, 32'h0, 3, "rd_stall", ta, to, d);
        n_total++;
        if (to - ta !== 6) $display("FAIL rd_stall latency: got %0d expected 6", to - ta);
        else n_pass++;
        n_total++;
        if (d !== 32'hDEADAAEF) $display("FAIL rd_stall data: got %h expected deadaaef", d);
        else n_pass++;
    endtask

    task automatic test_reset_inflight();
        int ta, to;
        logic [31:0] d;
        dbus_resp_t r;
        set_req(1'b0, 1'b1, 32'h200, 4'hF, 32'h12345678);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        r = get_resp(1'b0);
        n_total++;
        if (r.addr_ok !== 1'b0) $display("FAIL midreset addr_ok: got %b expected 0", r.addr_ok);
        else n_pass++;
        n_total++;
        if (r.data_ok !== 1'b0) $display("FAIL midreset data_ok: got %b expected 0", r.data_ok);
        else n_pass++;
        n_total++;
        if (r.data !== 32'h0) $display("FAIL midreset data: got %h expected 00000000", r.data);
        else n_pass++;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 32'h200, 4'h0, 32'h0, 0, "rd_dropped", ta, to, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rd_dropped data: got %h expected 00000000", d);
        else n_pass++;
    endtask

    task automatic test_alias_zero_latency();
        int ta, to;
        logic [31:0] d;
        txn(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 0, "wr_alias", ta, to, d);
        n_total++;
        if (to - ta !== 1) $display("FAIL wr_alias latency: got %0d expected 1", to - ta);
        else n_pass++;
        txn(1'b1, 32'h0, 4'h0, 32'h0, 0, "rd_alias", ta, to, d);
        n_total++;
        if (to - ta !== 1) $display("FAIL rd_alias latency: got %0d expected 1", to - ta);
        else n_pass++;
        n_total++;
        if (d !== 32'hCAFEF00D) $display("FAIL rd_alias data: got %h expected cafef00d", d);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_stall();
        test_reset_inflight();
        test_alias_zero_latency();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Memory-side responder for the core's data bus. It accepts one `dbus_req_t` transaction at a time from the core's `dreq` port, performs a byte-strobed write or a full-word read on an internal word-addressed SRAM after a programmable latency, and returns `dbus_resp_t`. It serves as the slave end of the dbus protocol for core-level simulation and for FPGA builds without a cache or AXI bridge.

## Interface
Parameters:
- `DEPTH`, 4096: SRAM size in 32-bit words; power of two.
- `LATENCY`, 2: wait cycles between accept and response, range 0–15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dreq`  in  `dbus_req_t`  request from the core: valid, addr, size, strobe, data.
- `dresp`  out  `dbus_resp_t`  response to the core: addr_ok, data_ok, data.
- `stall`  in  1  backpressure injection for test; tie to 0 in normal builds.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `addr_ok = dreq.valid & ~stall`, combinational.
  - On the accept edge, latch addr, strobe and data.
  - Go to WAIT with `cnt = LATENCY-1`. If `LATENCY == 0`, go straight to RESP.
- **WAIT**
  - If `stall` is high, `cnt` holds.
  - Otherwise, `cnt == 0` → RESP; else `cnt` decrements.
  - On the edge entering RESP:
    - Read (`strobe == 0`): `dresp.data` ← `mem[idx]`.
    - Write: `dresp.data` ← 0.
- **RESP**
  - `data_ok = 1` for exactly one cycle; `stall` is ignored here.
  - The write commits on the edge leaving RESP: for each i with `strobe[i]` set, `mem[idx][8i+7:8i]` ← `data[8i+7:8i]`.
  - Next state: IDLE.
- Index and width rules:
  - `idx = addr[$clog2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias modulo `DEPTH*4`.
  - `addr[1:0]` is ignored. The core supplies lane-aligned data and strobe.
  - `size` is ignored; `strobe` is authoritative.
  - Reads always return the full word; the core extracts the byte or halfword.
- Protocol contract:
  - The core holds `valid` and all request fields stable from assertion until it sees `data_ok`.
  - Requests arriving in WAIT or RESP are not accepted (`addr_ok = 0`).
  - Back-to-back requests are fine: a new `valid` in the cycle after `data_ok` is accepted in that cycle.
- Reset:
  - Asynchronous. State → IDLE, `cnt` → 0.
  - `addr_ok`, `data_ok` and `data` all go to 0 immediately.
  - An in-flight write that has not committed is dropped.
  - SRAM contents are not affected by reset. They are zero at simulation time zero.

## Timing
- Accept at cycle T (`addr_ok` high). With no stall, `data_ok` is high at T+1+LATENCY.
- Each stalled WAIT cycle adds one cycle of latency.
- A stalled IDLE cycle delays the accept itself.
- Earliest next accept is T+2+LATENCY, i.e. the cycle after `data_ok`.
- A read issued right after a write to the same word sees the new data, because the commit happens before the next accept.
- `data_ok` and `data` are registered outputs; `addr_ok` is combinational from state, `valid` and `stall`.
- Reset values: `addr_ok` = 0, `data_ok` = 0, `data` = 0.

## Structure
- Shared package (alongside the existing `dbus_req_t` / `dbus_resp_t` in common.svh):
  - `resp_state_t` enum {IDLE, WAIT, RESP}.
  - Constant `RESP_MAX_LATENCY` = 15.
- One sub-module, `bytewrite_ram`:
  - Parameter `DEPTH`.
  - Ports: `clk`, `we[3:0]`, `waddr`, `wdata`, `raddr`, `rdata`.
  - Synchronous write, asynchronous read.
  - Written so FPGA tools infer byte-enable BRAM.
- Top level holds the FSM, latency counter and request latches: about 150 lines total.

## Test plan
1. Reset with `dreq.valid = 1` held → `addr_ok`, `data_ok` and `data` all 0. Release reset → `addr_ok = 1` in the first cycle.
2. LATENCY=2. Write `addr=0x100`, `strobe=4'hF`, `data=0xDEADBEEF` at T → `data_ok` at T+3. Then read `0x100` → `data_ok` at T+7 with `data=0xDEADBEEF`.
3. Write `addr=0x100`, `strobe=4'b0010`, `data=0x0000AA00` → subsequent read returns `0xDEADAAEF`.
4. LATENCY=2, read accepted at T, `stall` high for 3 cycles during WAIT → `data_ok` at T+6.
5. Write `0x12345678` to `0x200`, assert reset during WAIT → outputs drop to 0 asynchronously. After release, a read of `0x200` returns its prior value of 0.
6. DEPTH=1024. Write `0xCAFEF00D` to `0x1000` → read of `0x0` returns `0xCAFEF00D`. With LATENCY=0, `data_ok` arrives one cycle after `addr_ok`.
